// File: rtl/mon_prod_radix.sv
// Radix-2^W Montgomery multiplier: R = X*Y*2^-NBITS mod M with operands streamed from word-wide RAM.
// Build option MON_PROD_SKIP_SUB_EN drops the final conditional subtraction (result left in [0,2m)).
module mon_prod_radix #(
    parameter int NBITS = 1024,
    parameter int DBITS = 512,
    parameter int ABITS = 8,
    parameter int W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [NBITS-1:0] m,
    input  logic [W-1:0]     m_inv,
    input  logic [ABITS-1:0] a_base,
    input  logic [ABITS-1:0] b_base,
    input  logic [ABITS-1:0] r_base,
    output logic [ABITS-1:0] rd_addr,
    input  logic [DBITS-1:0] rd_data,
    output logic             wr_en,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             busy,
    output logic             done
);
    localparam int NW = NBITS / DBITS;
    localparam int ND = NBITS / W;
    localparam int PW = NBITS + W + 1;
    // One extra bit above P so T + q*m never wraps before the shift.
    localparam int EW = NBITS + W + 2;
    localparam int CW = $clog2(ND + NW + 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
`ifndef MON_PROD_SKIP_SUB_EN
        REDUCE,
`endif
        STORE,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_r;
    logic [ABITS-1:0] a_base_r, b_base_r, r_base_r;
    logic [NBITS-1:0] a_reg, b_reg;
    logic [PW-1:0]    p_reg;
    logic [CW-1:0]    cnt;
    logic [ABITS-1:0] rd_off;

    function automatic logic [PW-1:0] mont_step(
        input logic [PW-1:0]    p,
        input logic [NBITS-1:0] a,
        input logic [W-1:0]     b,
        input logic [NBITS-1:0] mod,
        input logic [W-1:0]     mu
    );
        logic [EW-1:0]  t;
        logic [2*W-1:0] qp;
        logic [EW-1:0]  s;
        t  = EW'(p) + EW'(b) * EW'(a);
        qp = {{W{1'b0}}, t[W-1:0]} * {{W{1'b0}}, mu};
        s  = t + EW'(qp[W-1:0]) * EW'(mod);
        return PW'(s >> W);
    endfunction

`ifndef MON_PROD_SKIP_SUB_EN
    function automatic logic [PW-1:0] cond_sub(
        input logic [PW-1:0]    p,
        input logic [NBITS-1:0] mod
    );
        if (p >= PW'(mod)) return p - PW'(mod);
        return p;
    endfunction
`endif

    // The extra load cycle re-reads word 0 so nothing outside the operand is touched.
    assign rd_off = (cnt < CW'(NW)) ? ABITS'(cnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD_A;
            LOAD_A: begin
                busy    = 1'b1;
                rd_addr = a_base_r + rd_off;
                if (cnt == CW'(NW)) state_nxt = (op_r == 2'd0) ? LOAD_B : CALC;
            end
            LOAD_B: begin
                busy    = 1'b1;
                rd_addr = b_base_r + rd_off;
                if (cnt == CW'(NW)) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
`ifdef MON_PROD_SKIP_SUB_EN
                if (cnt == CW'(ND - 1)) state_nxt = STORE;
`else
                if (cnt == CW'(ND - 1)) state_nxt = REDUCE;
`endif
            end
`ifndef MON_PROD_SKIP_SUB_EN
            REDUCE: begin
                busy      = 1'b1;
                state_nxt = STORE;
            end
`endif
            STORE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = r_base_r + ABITS'(cnt);
                wr_data = p_reg[DBITS-1:0];
                if (cnt == CW'(NW - 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= '0;
            a_base_r <= '0;
            b_base_r <= '0;
            r_base_r <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            p_reg    <= '0;
            cnt      <= '0;
        end else begin
            cnt <= (state == IDLE || state_nxt != state) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    op_r     <= op;
                    a_base_r <= a_base;
                    b_base_r <= b_base;
                    r_base_r <= r_base;
                    p_reg    <= '0;
                end
                // Words arrive low first and are shifted in from the top.
                LOAD_A: begin
                    if (cnt != '0) begin
                        a_reg <= NBITS'({rd_data, a_reg} >> DBITS);
                        if (op_r == 2'd1) b_reg <= NBITS'({rd_data, b_reg} >> DBITS);
                    end
                    if (op_r[1]) b_reg <= NBITS'(1);
                end
                LOAD_B: if (cnt != '0) b_reg <= NBITS'({rd_data, b_reg} >> DBITS);
                CALC: begin
                    p_reg <= mont_step(p_reg, a_reg, b_reg[W-1:0], m, m_inv);
                    b_reg <= b_reg >> W;
                end
`ifndef MON_PROD_SKIP_SUB_EN
                REDUCE: p_reg <= cond_sub(p_reg, m);
`endif
                STORE: p_reg <= p_reg >> DBITS;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mon_prod_radix.sv
// Bench for mon_prod_radix at NBITS=8, DBITS=4, W=2 with a behavioural RAM and an integer reference model.
module tb_mon_prod_radix;
    localparam int NBITS = 8;
    localparam int DBITS = 4;
    localparam int ABITS = 8;
    localparam int W     = 2;
    localparam int NW    = 2;
    localparam int ND    = 4;
`ifdef MON_PROD_SKIP_SUB_EN
    localparam int RED = 0;
`else
    localparam int RED = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = '0;
    logic [NBITS-1:0] m = '0;
    logic [W-1:0]     m_inv = '0;
    logic [ABITS-1:0] a_base = '0, b_base = '0, r_base = '0;
    logic [ABITS-1:0] rd_addr, wr_addr;
    logic [DBITS-1:0] rd_data, wr_data;
    logic             wr_en, busy, done;

    mon_prod_radix #(.NBITS(NBITS), .DBITS(DBITS), .ABITS(ABITS), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .m(m), .m_inv(m_inv),
        .a_base(a_base), .b_base(b_base), .r_base(r_base),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DBITS-1:0] mem [0:255];
    logic             ld_en = 1'b0;
    logic [ABITS-1:0] ld_addr = '0;
    logic [DBITS-1:0] ld_data = '0;
    logic [ABITS-1:0] watch_lo = 8'd2;
    int write_cnt = 0, watch_rd = 0, done_cnt = 0;

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            write_cnt    <= write_cnt + 1;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (busy && rd_addr >= watch_lo && int'(rd_addr) < int'(watch_lo) + NW) watch_rd <= watch_rd + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Montgomery product from first principles: x*y*inverse(2^NBITS) mod m.
    function automatic int mont_ref(input int x, input int y, input int md);
        int rinv = 0;
        for (int k = 1; k < md; k++) if (((1 << NBITS) * k) % md == 1) rinv = k;
        return (((x * y) % md) * rinv) % md;
    endfunction

    function automatic int minv_ref(input int md);
        for (int q = 0; q < (1 << W); q++) if ((md * q + 1) % (1 << W) == 0) return q;
        return 0;
    endfunction

    function automatic int lat_ref(input int opv);
        return (NW + 1) * ((opv == 0) ? 2 : 1) + ND + RED + NW;
    endfunction

    task automatic chk_res(input string name, input int got, input int want, input int md);
        checks++;
`ifdef MON_PROD_SKIP_SUB_EN
        if (!(got < 2 * md && got % md == want)) begin
`else
        if (got !== want) begin
`endif
            errors++;
            $display("FAIL %s got %0d want %0d (mod %0d)", name, got, want, md);
        end
    endtask

    task automatic poke(input int addr, input int d);
        ld_en   = 1'b1;
        ld_addr = ABITS'(addr);
        ld_data = DBITS'(d);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic poke_op(input int base, input int val);
        poke(base, val & 15);
        poke(base + 1, (val >> 4) & 15);
    endtask

    function automatic int peek_op(input int base);
        return int'(mem[base]) + 16 * int'(mem[base + 1]);
    endfunction

    task automatic issue(input int opv, input int md, input int ab, input int bb, input int rb);
        m      = NBITS'(md);
        m_inv  = W'(minv_ref(md));
        op     = 2'(opv);
        a_base = ABITS'(ab);
        b_base = ABITS'(bb);
        r_base = ABITS'(rb);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input int opv, input int xa, input int xb, input int md,
                          input int ab, input int bb, input int rb,
                          output int res, output int lat, output int bcyc);
        poke_op(ab, xa);
        if (opv == 0) poke_op(bb, xb);
        issue(opv, md, ab, bb, rb);
        lat  = -1;
        bcyc = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcyc++;
        end
        res = peek_op(rb);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int opv;
        int xa;
        int xb;
        int md;
        int want;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL global_timeout got 0 want 1");
        $fatal(1, "timeout");
    end

    initial begin
        int res, lat, bcyc, w0, d0, r0, yv, xa, xb, md, opv;
        tbl[0] = '{0, 5, 7, 13, 1};
        tbl[1] = '{1, 5, 7, 13, 10};
        tbl[2] = '{2, 5, 7, 13, 2};
        tbl[3] = '{0, 0, 7, 13, 0};
        tbl[4] = '{0, 12, 12, 13, 3};
        tbl[5] = '{3, 5, 7, 13, 2};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        poke_op(2, 7);
        for (int i = 0; i < 6; i++) begin
            r0 = watch_rd;
            run_op(tbl[i].opv, tbl[i].xa, tbl[i].xb, tbl[i].md, 0, 2, 4, res, lat, bcyc);
            chk_res($sformatf("tbl%0d_result", i), res, tbl[i].want, tbl[i].md);
            chk($sformatf("tbl%0d_latency", i), lat, lat_ref(tbl[i].opv));
            chk($sformatf("tbl%0d_busy_cycles", i), bcyc, lat_ref(tbl[i].opv));
            if (tbl[i].opv != 0) chk($sformatf("tbl%0d_b_reads", i), watch_rd - r0, 0);
        end

        // In-place multiply: result overwrites A, B untouched.
        poke_op(0, 5);
        poke_op(2, 7);
        run_op(0, 5, 7, 13, 0, 2, 0, res, lat, bcyc);
        chk("inplace_lo", int'(mem[0]), 1);
        chk("inplace_hi", int'(mem[1]), 0);
        chk("inplace_b_lo", int'(mem[2]), 7);
        chk("inplace_b_hi", int'(mem[3]), 0);

        // Reset while in CALC aborts without writing.
        poke_op(0, 5);
        poke_op(2, 7);
        issue(0, 13, 0, 2, 8);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_rd_addr", int'(rd_addr), 0);
        w0 = write_cnt;
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_writes", write_cnt - w0, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 12, 12, 13, 0, 2, 6, res, lat, bcyc);
        chk_res("after_abort_result", res, 3, 13);
        chk("after_abort_latency", lat, lat_ref(0));

        // start pulsed while busy is ignored.
        poke_op(0, 5);
        poke_op(2, 7);
        d0 = done_cnt;
        issue(0, 13, 0, 2, 4);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("busy_start_single_done", done_cnt - d0, 1);
        chk("busy_start_idle", int'(busy), 0);
        chk_res("busy_start_result", peek_op(4), 1, 13);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            md  = 2 * int'($urandom_range(1, 127)) + 1;
            xa  = int'($urandom_range(0, md - 1));
            xb  = int'($urandom_range(0, md - 1));
            opv = int'($urandom_range(0, 3));
            yv  = (opv == 0) ? xb : (opv == 1) ? xa : 1;
            run_op(opv, xa, xb, md, 16, 32, 48, res, lat, bcyc);
            chk_res($sformatf("rand%0d_op%0d_m%0d_a%0d_b%0d", i, opv, md, xa, xb), res, mont_ref(xa, yv, md), md);
            chk($sformatf("rand%0d_latency", i), lat, lat_ref(opv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mon_prod_radix.md
Name: mon_prod_radix

Overview:
Parametrised radix-2^W Montgomery multiplier, successor to the fixed 1024-bit radix-2 multiplier. It computes R = X*Y*2^-NBITS mod M and adds an asynchronous reset, a busy/done handshake, programmable operand and result base addresses, and a selectable digit width. Operands stream from a word-wide synchronous RAM and the result is written back to it. It sits under the modular-exponentiation controller, which issues MUL/SQR/FROM operations.

Parameters:
NBITS, 1024, modulus/operand width; multiple of DBITS and of W
DBITS, 512, RAM word width; NW = NBITS/DBITS words per operand
ABITS, 8, RAM address width
W, 2, digit width in bits (radix 2^W); ND = NBITS/W iterations

Ports:
clk  in  1  clock, all flops rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  0=MUL (A*B), 1=SQR (A*A), 2=FROM (A*1), 3=reserved (treated as FROM)
m  in  NBITS  odd modulus, held stable while busy
m_inv  in  W  mu = -m^-1 mod 2^W, held stable while busy
a_base  in  ABITS  base word address of A
b_base  in  ABITS  base word address of B (MUL only)
r_base  in  ABITS  base word address of result
rd_addr  out  ABITS  RAM read address
rd_data  in  DBITS  RAM data; valid one cycle after rd_addr is driven
wr_en  out  1  RAM write strobe
wr_addr  out  ABITS  RAM write address
wr_data  out  DBITS  RAM write data
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE; rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; P, A, B, counters cleared. Reset mid-operation aborts with no further writes.
- Operand layout: word j of an operand is at base+j, j=0..NW-1, low word first. The result uses the same layout at r_base.
- IDLE: start=1 latches op and the bases; busy=1; go to LOAD_A. start=0 holds. start while busy is ignored.
- LOAD_A: NW+1 cycles; one address per cycle; rd_data captured the cycle after each address. SQR copies A into B. FROM sets B=1.
- LOAD_B (MUL only): NW+1 cycles, same scheme from b_base.
- CALC: ND cycles, one digit per cycle, LSB digit first. b=B[W-1:0]; T=P+b*A; q=(T[W-1:0]*m_inv) mod 2^W; P=(T+q*m)>>W; B>>=W.
- P register width is NBITS+W+1; no overflow given A,B < m. The invariant P < 2m holds after each iteration.
- REDUCE: 1 cycle; if P >= m then P=P-m.
- STORE: NW cycles; wr_en=1 and wr_addr=r_base+j with word j of P. wr_en=0 afterwards.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start may be accepted in the following cycle.
- Latency from the start-sampling edge to done high is L = (NW+1)*(2 if MUL else 1) + ND + 1 + NW.
- Overlap: r_base may equal a_base or b_base, since all reads complete before the first write.
- Precondition: A,B < m and m odd. Outputs for violating inputs are unspecified but must not hang: done is always reached in L cycles.

Optional Feature:
MON_PROD_SKIP_SUB_EN
- Defined: the REDUCE state is removed. The result is P in [0,2m), congruent to the Montgomery product mod m, and L is one cycle shorter. This is for chained exponentiation where the final reduction is done once at the end.
- Undefined: REDUCE is present and the result is fully reduced in [0,m).

Test Plan:
NBITS=8, DBITS=4, W=2, m=13, m_inv=3, A=5@0x00, B=7@0x02, MUL, r_base=0x04 -> mem[4]=1, mem[5]=0; done at start-edge+13; busy high 13 cycles.
Same setup, SQR -> result 10 (mem[4]=0xA, mem[5]=0) at start-edge+10; no reads from b_base.
Same setup, FROM -> result 2; A=0 MUL -> result 0; A=12, B=12 MUL -> 144*3 mod 13 = 3.
In-place MUL with r_base=a_base=0x00 -> mem[0]=1, mem[1]=0; B words at 0x02/0x03 unchanged.
rst_n low during CALC -> outputs at reset values immediately with no wr_en pulse; a fresh start then completes correctly. start pulsed while busy -> ignored, single done.
MON_PROD_SKIP_SUB_EN defined: m=13, A=12, B=12 MUL -> result in {3,16}, congruent to 3 mod 13, done at start-edge+12.
